// File: rtl/countdown8_if.sv
// Control/status bundle for the countdown8 timer: the master drives commands,
// the slave (timer) returns count and status.
interface countdown8_if #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
);
  logic                  load;
  logic [WIDTH-1:0]      load_val;
  logic                  auto_reload;
  logic [PRESCALE_W-1:0] presc;
  logic                  pause;
  logic                  abort;
  logic [WIDTH-1:0]      v;
  logic                  busy;
  logic                  tc;
  logic                  done;

  modport master (output load, load_val, auto_reload, presc, pause, abort,
                  input  v, busy, tc, done);
  modport slave  (input  load, load_val, auto_reload, presc, pause, abort,
                  output v, busy, tc, done);
endinterface

// File: rtl/countdown8.sv
// Loadable prescaled down-counter with one-shot / auto-reload modes and a
// single-cycle terminal-count pulse. All outputs are registered.
module countdown8 #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
) (
  input logic         clk,
  input logic         reset,
  countdown8_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [WIDTH-1:0]      v_q, reload_q;
  logic [PRESCALE_W-1:0] pcnt, presc_l;
  logic                  mode_q, busy_q, tc_q, done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      v_q      <= '0;
      reload_q <= '0;
      pcnt     <= '0;
      presc_l  <= '0;
      mode_q   <= 1'b0;
      busy_q   <= 1'b0;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (bus.abort) begin
        state  <= IDLE;
        v_q    <= '0;
        pcnt   <= '0;
        busy_q <= 1'b0;
        done_q <= 1'b0;
      end else if (bus.load) begin
        reload_q <= bus.load_val;
        mode_q   <= bus.auto_reload;
        presc_l  <= bus.presc;
        pcnt     <= '0;
        v_q      <= bus.load_val;
        // A zero start value completes immediately without a tc pulse.
        if (bus.load_val != '0) begin
          state  <= RUN;
          busy_q <= 1'b1;
          done_q <= 1'b0;
        end else begin
          state  <= DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end else if (state == RUN && !bus.pause) begin
        if (pcnt != presc_l) begin
          pcnt <= pcnt + 1'b1;
        end else begin
          pcnt <= '0;
          if (v_q > WIDTH'(1)) begin
            v_q <= v_q - 1'b1;
          end else if (mode_q) begin
            v_q  <= reload_q;
            tc_q <= 1'b1;
          end else begin
            v_q    <= '0;
            tc_q   <= 1'b1;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= DONE;
          end
        end
      end
    end
  end

  assign bus.v    = v_q;
  assign bus.busy = busy_q;
  assign bus.tc   = tc_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_countdown8.sv
// Bench for countdown8: directed vector table, hand-written latency/reset
// sequences, and random stimulus against an elapsed-time reference model.
module tb_countdown8;
  localparam int W  = 8;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  countdown8_if #(.WIDTH(W), .PRESCALE_W(PW)) bus();
  countdown8 #(.WIDTH(W), .PRESCALE_W(PW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  // Model: time since load in unpaused running clocks; count derives from it.
  bit m_act, m_done, m_tc, m_mode;
  int m_L, m_P, m_e;

  function automatic int m_v();
    if (!m_act) return 0;
    return m_L - m_e / (m_P + 1);
  endfunction

  task automatic m_reset();
    m_act = 0; m_done = 0; m_tc = 0; m_mode = 0; m_L = 0; m_P = 0; m_e = 0;
  endtask

  task automatic m_edge();
    m_tc = 0;
    if (bus.abort) begin
      m_act = 0; m_done = 0;
    end else if (bus.load) begin
      m_L = int'(bus.load_val); m_P = int'(bus.presc); m_mode = bus.auto_reload;
      m_e = 0; m_act = (m_L != 0); m_done = (m_L == 0);
    end else if (m_act && !bus.pause) begin
      m_e++;
      if (m_e == m_L * (m_P + 1)) begin
        m_tc = 1;
        if (m_mode) m_e = 0;
        else begin m_act = 0; m_done = 1; end
      end
    end
  endtask

  task automatic check(input string name, input int ev, input bit eb, input bit et, input bit ed);
    vectors++;
    if (int'(bus.v) != ev || bus.busy != eb || bus.tc != et || bus.done != ed) begin
      miscompares++;
      $display("FAIL %s @%0t: got v=%0d busy=%0b tc=%0b done=%0b, expected v=%0d busy=%0b tc=%0b done=%0b",
               name, $time, bus.v, bus.busy, bus.tc, bus.done, ev, eb, et, ed);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic drive(input bit l, input int lv, input bit ar, input int p, input bit pa, input bit ab);
    bus.load = l; bus.load_val = W'(lv); bus.auto_reload = ar;
    bus.presc = PW'(p); bus.pause = pa; bus.abort = ab;
  endtask

  task automatic cyc(input string name);
    @(posedge clk);
    m_edge();
    #1;
    check(name, m_v(), m_act, m_tc, m_done);
  endtask

  task automatic wait_tc(input string name, input int bound, output int n);
    n = 0;
    do begin
      cyc(name);
      n++;
    end while (!bus.tc && n < bound);
  endtask

  typedef struct {
    bit l; int lv; bit ar; int p; bit pa; bit ab;
    int ev; bit eb; bit et; bit ed;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int n, n2;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    m_reset();
    #3;
    check("reset_state", 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // l lv ar p pa ab | v busy tc done
    tbl.push_back('{1, 5, 0, 0, 0, 0, 5, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 4, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 3, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 2, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{1, 3, 0, 0, 0, 0, 3, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 2, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 1, 0, 0});
    tbl.push_back('{1, 7, 0, 0, 0, 0, 7, 1, 0, 0});  // load beats terminal tick
    tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{1, 2, 0, 0, 0, 0, 2, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 0, 2, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 0, 2, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 2, 0, 0, 1, 0, 2, 1, 0, 0});  // load beats pause
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 1, 0, 0});
    tbl.push_back('{1, 1, 1, 0, 0, 0, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 1, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 1, 1, 0});
    tbl.push_back('{1, 9, 0, 0, 0, 1, 0, 0, 0, 0});  // abort beats load
    foreach (tbl[i]) begin
      drive(tbl[i].l, tbl[i].lv, tbl[i].ar, tbl[i].p, tbl[i].pa, tbl[i].ab);
      @(posedge clk);
      m_edge();
      #1;
      check($sformatf("table[%0d]", i), tbl[i].ev, tbl[i].eb, tbl[i].et, tbl[i].ed);
    end

    // Auto-reload period: load 3, presc 2 -> tc every 9 clocks.
    drive(1, 3, 1, 2, 0, 0); cyc("ar_load");
    drive(0, 0, 0, 0, 0, 0);
    wait_tc("ar_run", 40, n);  check_int("ar_first_tc", n, 9);
    wait_tc("ar_run", 40, n);  check_int("ar_period", n, 9);
    drive(1, 3, 0, 0, 1, 1); cyc("ar_abort");

    // Pause of 4 clocks delays tc by 4 (8 instead of 4).
    drive(1, 4, 0, 0, 0, 0); cyc("p_load");
    drive(0, 0, 0, 0, 0, 0); cyc("p_run"); cyc("p_run");
    drive(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc("p_hold");
    drive(0, 0, 0, 0, 0, 0);
    wait_tc("p_run", 20, n2);  check_int("pause_latency", 6 + n2, 8);

    // Max start value.
    drive(1, 255, 0, 0, 0, 0); cyc("max_load");
    drive(0, 0, 0, 0, 0, 0);
    wait_tc("max_run", 300, n); check_int("max_tc_latency", n, 255);

    // Async reset mid-run, between edges.
    drive(1, 9, 1, 3, 0, 0); cyc("rst_load");
    drive(0, 0, 0, 0, 0, 0); cyc("rst_run"); cyc("rst_run");
    #2 reset = 1'b1;
    #1 check("async_reset", 0, 0, 0, 0);
    m_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    cyc("post_reset_idle");

    for (int i = 0; i < 3000; i++) begin
      bit l, ab;
      l  = ($urandom_range(0, 15) == 0);
      ab = ($urandom_range(0, 59) == 0);
      drive(l, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6)),
            1'($urandom), int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0), ab);
      cyc("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
